// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode constants, data-path width and the ID/EX bundle.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] ANDI_OP = 6'h0C;
    localparam logic [5:0] ORI_OP  = 6'h0D;
    localparam logic [5:0] XORI_OP = 6'h0E;
    localparam logic [5:0] TRAP_OP = 6'h1A;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_8;
        logic [4:0]      rs_field;
        logic [4:0]      rt_field;
        logic [4:0]      rd_field;
    } id_ex_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == ANDI_OP) || (op == ORI_OP) || (op == XORI_OP);
    endfunction

endpackage

// File: rtl/rf_bank.sv
// One general-register bank: NREG x XLEN, two read ports, one write port, r0 hard-wired to zero.
module rf_bank #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_a,
    output logic [XLEN-1:0] rd_data_b
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/id_stage_banked.sv
// Banked decode stage with branch-operand forwarding and the ID/EX pipeline register.
// ID_BANK_SWITCH_EN enables NBANK mode-selected banks; without it a single bank is built.
module id_stage_banked #(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREG  = 32,
    parameter int NBANK = 2,
    parameter int AW    = $clog2(NREG),
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] pc_4_in,
    input  logic            valid_in,
    input  logic [BW-1:0]   bank_sel,
    input  logic            wr_n,
    input  logic [BW-1:0]   wr_bank,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            fwd_c,
    input  logic            fwd_d,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] rs_fwd,
    output logic [XLEN-1:0] rt_fwd,
    output logic [XLEN-1:0] branch,
    output logic [27:0]     offset28,
    output logic [XLEN-1:0] rs_q,
    output logic [XLEN-1:0] rt_q,
    output logic [XLEN-1:0] imm_q,
    output logic [XLEN-1:0] pc_8_q,
    output logic [4:0]      rs_field_q,
    output logic [4:0]      rt_field_q,
    output logic [4:0]      rd_field_q,
    output logic [BW-1:0]   bank_q,
    output logic            valid_q
);
    import cpu_pkg::*;

`ifdef ID_BANK_SWITCH_EN
    localparam int NB = NBANK;
`else
    localparam int NB = 1;
`endif

    logic [AW-1:0]   rs_addr, rt_addr;
    logic [XLEN-1:0] rd_a [NB];
    logic [XLEN-1:0] rd_b [NB];
    logic [XLEN-1:0] rs_rd, rt_rd, rs_byp, rt_byp, imm;
    logic [BW-1:0]   bank_cap, bank_r;
    logic            bank_hit_rd, bank_hit_q, wr_en;
    id_ex_t          id_ex;

    assign rs_addr = ins[21 +: AW];
    assign rt_addr = ins[16 +: AW];
    assign wr_en   = !wr_n;

    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic bank_we;
`ifdef ID_BANK_SWITCH_EN
        assign bank_we = wr_en && (wr_bank == BW'(g));
`else
        assign bank_we = wr_en;
`endif
        rf_bank #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf_bank (
            .clk       (clk),
            .reset     (reset),
            .we        (bank_we),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_addr_a (rs_addr),
            .rd_addr_b (rt_addr),
            .rd_data_a (rd_a[g]),
            .rd_data_b (rd_b[g])
        );
    end

`ifdef ID_BANK_SWITCH_EN
    assign rs_rd       = rd_a[bank_sel];
    assign rt_rd       = rd_b[bank_sel];
    assign bank_hit_rd = (wr_bank == bank_sel);
    assign bank_hit_q  = (wr_bank == bank_r);
    assign bank_cap    = bank_sel;
`else
    logic unused_bank;
    assign unused_bank = ^{bank_sel, wr_bank};
    assign rs_rd       = rd_a[0];
    assign rt_rd       = rd_b[0];
    assign bank_hit_rd = 1'b1;
    assign bank_hit_q  = 1'b1;
    assign bank_cap    = '0;
`endif

    // Write-through so a same-cycle write-back is seen by this decode.
    assign rs_byp = (wr_en && bank_hit_rd && (wr_addr == rs_addr) && (rs_addr != '0)) ? wr_data : rs_rd;
    assign rt_byp = (wr_en && bank_hit_rd && (wr_addr == rt_addr) && (rt_addr != '0)) ? wr_data : rt_rd;

    assign rs_fwd = fwd_c ? ex_mem_data : rs_byp;
    assign rt_fwd = fwd_d ? ex_mem_data : rt_byp;

    assign imm      = is_zext_op(ins[31:26]) ? {{(XLEN-16){1'b0}}, ins[15:0]}
                                             : {{(XLEN-16){ins[15]}}, ins[15:0]};
    assign branch   = (imm << 2) + pc_4_in;
    assign offset28 = {ins[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_ex  <= '0;
            bank_r <= '0;
        end else if (flush) begin
            id_ex  <= '0;
            bank_r <= '0;
        end else if (stall) begin
            // Held instruction must not keep an operand that write-back just replaced.
            if (wr_en && bank_hit_q && (wr_addr != '0) && (5'(wr_addr) == id_ex.rs_field))
                id_ex.rs <= wr_data;
            if (wr_en && bank_hit_q && (wr_addr != '0) && (5'(wr_addr) == id_ex.rt_field))
                id_ex.rt <= wr_data;
        end else begin
            id_ex.valid    <= valid_in;
            id_ex.rs       <= rs_byp;
            id_ex.rt       <= rt_byp;
            id_ex.imm      <= imm;
            id_ex.pc_8     <= pc_4_in + XLEN'(4);
            id_ex.rs_field <= ins[25:21];
            id_ex.rt_field <= ins[20:16];
            id_ex.rd_field <= ins[15:11];
            bank_r         <= bank_cap;
        end
    end

    assign valid_q    = id_ex.valid;
    assign rs_q       = id_ex.rs;
    assign rt_q       = id_ex.rt;
    assign imm_q      = id_ex.imm;
    assign pc_8_q     = id_ex.pc_8;
    assign rs_field_q = id_ex.rs_field;
    assign rt_field_q = id_ex.rt_field;
    assign rd_field_q = id_ex.rd_field;
    assign bank_q     = bank_r;

endmodule

// File: tb/tb_id_stage_banked.sv
// Directed self-checking bench for id_stage_banked; expectations adapt to ID_BANK_SWITCH_EN.
module tb_id_stage_banked;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins, pc_4_in, wr_data, ex_mem_data;
    logic        valid_in, wr_n, fwd_c, fwd_d, stall, flush;
    logic [0:0]  bank_sel, wr_bank, bank_q;
    logic [4:0]  wr_addr, rs_field_q, rt_field_q, rd_field_q;
    logic [31:0] rs_fwd, rt_fwd, branch, rs_q, rt_q, imm_q, pc_8_q;
    logic [27:0] offset28;
    logic        valid_q;

    int checks = 0;
    int errors = 0;

    id_stage_banked dut (
        .clk(clk), .reset(reset), .ins(ins), .pc_4_in(pc_4_in), .valid_in(valid_in),
        .bank_sel(bank_sel), .wr_n(wr_n), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .fwd_c(fwd_c), .fwd_d(fwd_d), .ex_mem_data(ex_mem_data),
        .stall(stall), .flush(flush), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .branch(branch),
        .offset28(offset28), .rs_q(rs_q), .rt_q(rt_q), .imm_q(imm_q), .pc_8_q(pc_8_q),
        .rs_field_q(rs_field_q), .rt_field_q(rt_field_q), .rd_field_q(rd_field_q),
        .bank_q(bank_q), .valid_q(valid_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] br;
        logic [27:0] off;
        logic [31:0] pc8;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[6];

`ifdef ID_BANK_SWITCH_EN
    localparam logic [31:0] BANK0_R5 = 32'h0;
`else
    localparam logic [31:0] BANK0_R5 = 32'hDEAD_BEEF;
`endif

    initial begin
        vecs[0] = '{32'h3422_8000, 32'h0000_0100, 32'h0000_8000, 32'h0002_0100, 28'h08A_0000, 32'h0000_0104, 5'd16};
        vecs[1] = '{32'h2022_8000, 32'h0000_0100, 32'hFFFF_8000, 32'hFFFE_0100, 28'h08A_0000, 32'h0000_0104, 5'd16};
        vecs[2] = '{32'h2000_FFFF, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_00FC, 28'h003_FFFC, 32'h0000_0104, 5'd31};
        vecs[3] = '{32'h3000_FFFF, 32'h0000_0200, 32'h0000_FFFF, 32'h0004_01FC, 28'h003_FFFC, 32'h0000_0204, 5'd31};
        vecs[4] = '{32'h3864_8001, 32'h0000_1000, 32'h0000_8001, 32'h0002_1004, 28'h192_0004, 32'h0000_1004, 5'd16};
        vecs[5] = '{32'h0BFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 28'hFFF_FFFC, 32'h0000_0000, 5'd31};

        reset = 1'b0; ins = 32'h2025_1234; pc_4_in = 32'h40; valid_in = 1'b1;
        bank_sel = 1'b0; wr_bank = 1'b0; wr_n = 1'b0; wr_addr = 5'd5; wr_data = 32'hAAAA;
        fwd_c = 1'b0; fwd_d = 1'b0; ex_mem_data = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("reset valid_q", {31'b0, valid_q}, 32'h0);
        chk("reset rs_q", rs_q, 32'h0);
        chk("reset imm_q", imm_q, 32'h0);
        chk("reset pc_8_q", pc_8_q, 32'h0);
        chk("reset rd_field_q", {27'b0, rd_field_q}, 32'h0);
        reset = 1'b1; wr_n = 1'b1; ins = 32'h00A5_0000;  // rs=r5, rt=r5
        #1;
        chk("reset r5 reads 0", rs_fwd, 32'h0);

        // Bank isolation
        tick();
        ins = 32'h0; wr_n = 1'b0; wr_bank = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_n = 1'b1; ins = 32'h00A0_0000; bank_sel = 1'b0;
        #1;
        chk("bank0 r5", rs_fwd, BANK0_R5);
        bank_sel = 1'b1;
        #1;
        chk("bank1 r5", rs_fwd, 32'hDEAD_BEEF);

        // Write-through bypass and branch forwarding
        tick();
        bank_sel = 1'b0; ins = 32'h00E5_0000;  // rs=r7, rt=r5
        wr_n = 1'b0; wr_bank = 1'b0; wr_addr = 5'd7; wr_data = 32'h1234;
        #1;
        chk("bypass rs_fwd", rs_fwd, 32'h1234);
        tick();
        chk("bypass rs_q", rs_q, 32'h1234);
        wr_n = 1'b1; fwd_c = 1'b1; ex_mem_data = 32'h55;
        #1;
        chk("fwd_c rs_fwd", rs_fwd, 32'h55);
        chk("no fwd_d rt_fwd", rt_fwd, BANK0_R5);
        fwd_d = 1'b1;
        #1;
        chk("fwd_d rt_fwd", rt_fwd, 32'h55);
        tick();
        chk("fwd keeps rs_q", rs_q, 32'h1234);
        fwd_c = 1'b0; fwd_d = 1'b0;

        // Immediate / target vectors
        for (int i = 0; i < 6; i++) begin
            ins = vecs[i].ins; pc_4_in = vecs[i].pc4; valid_in = 1'b1;
            #1;
            chk($sformatf("v%0d branch", i), branch, vecs[i].br);
            chk($sformatf("v%0d offset28", i), {4'b0, offset28}, {4'b0, vecs[i].off});
            tick();
            chk($sformatf("v%0d imm_q", i), imm_q, vecs[i].imm);
            chk($sformatf("v%0d pc_8_q", i), pc_8_q, vecs[i].pc8);
            chk($sformatf("v%0d rd_field_q", i), {27'b0, rd_field_q}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d valid_q", i), {31'b0, valid_q}, 32'h1);
        end
        valid_in = 1'b0;
        tick();
        chk("bubble valid_q", {31'b0, valid_q}, 32'h0);

        // Stall with stale-operand refresh
        ins = 32'h2023_1234; pc_4_in = 32'h40; valid_in = 1'b1;  // rs=r1 rt=r3 rd=2
        tick();
        chk("stall setup rt_field_q", {27'b0, rt_field_q}, 32'd3);
        stall = 1'b1; ins = 32'h0; pc_4_in = 32'h999; valid_in = 1'b0;
        wr_n = 1'b0; wr_bank = 1'b0; wr_addr = 5'd3; wr_data = 32'h99;
        tick();
        wr_n = 1'b1;
        chk("stall rt_q refresh", rt_q, 32'h99);
        chk("stall rs_q hold", rs_q, 32'h0);
        chk("stall imm_q hold", imm_q, 32'h1234);
        chk("stall pc_8_q hold", pc_8_q, 32'h44);
        chk("stall rd_field_q hold", {27'b0, rd_field_q}, 32'd2);
        chk("stall valid_q hold", {31'b0, valid_q}, 32'h1);

        // Flush beats stall; r0 stays zero
        flush = 1'b1;
        tick();
        chk("flush valid_q", {31'b0, valid_q}, 32'h0);
        chk("flush imm_q", imm_q, 32'h0);
        chk("flush pc_8_q", pc_8_q, 32'h0);
        chk("flush rt_q", rt_q, 32'h0);
        flush = 1'b0; stall = 1'b0;
        ins = 32'h0; wr_n = 1'b0; wr_addr = 5'd0; wr_data = 32'hFFFF;
        #1;
        chk("r0 no bypass", rs_fwd, 32'h0);
        tick();
        wr_n = 1'b1;
        #1;
        chk("r0 reads 0", rs_fwd, 32'h0);

        // Reset during a stall discards the held instruction and clears banks
        ins = 32'h20E3_0010; pc_4_in = 32'h80; valid_in = 1'b1;
        tick();
        chk("pre-reset valid_q", {31'b0, valid_q}, 32'h1);
        stall = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1; stall = 1'b0; valid_in = 1'b0;
        chk("reset-in-stall valid_q", {31'b0, valid_q}, 32'h0);
        chk("reset-in-stall imm_q", imm_q, 32'h0);
        #1;
        chk("reset clears r7", rs_fwd, 32'h0);
        chk("reset clears r3", rt_fwd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_banked.md
# id_stage_banked

Parametrised decode stage for the 5-stage pipeline. It owns `NBANK` general-register banks, selected by processor mode, and applies forwarding to the branch operands. It computes the immediate, jump and branch targets, and registers the decoded instruction into an ID/EX pipeline register with stall/flush control. It sits between the IF/ID register and the EX stage; the decode ROM and branch comparator stay external.

## Interface
- `XLEN`, 32: data-path width.
- `NREG`, 32: registers per bank; power of two; `AW = $clog2(NREG)`.
- `NBANK`, 2: register banks, indexed by `bank_sel`/`wr_bank`; forced to 1 without the macro.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; clears banks and the pipeline register.
- `ins` in 32: instruction from IF/ID.
- `pc_4_in` in XLEN: PC+4 of `ins`.
- `valid_in` in 1: `ins` is a real instruction.
- `bank_sel` in `$clog2(NBANK)` (min 1): read bank (0 = supervisor, 1 = user).
- `wr_n` in 1: write-back strobe, active-low.
- `wr_bank` in `$clog2(NBANK)`: write-back bank.
- `wr_addr` in AW: write-back register.
- `wr_data` in XLEN: write-back data.
- `fwd_c`, `fwd_d` in 1: replace the rs/rt branch operand with `ex_mem_data`.
- `ex_mem_data` in XLEN: EX/MEM result.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: insert a bubble into ID/EX.
- `rs_fwd`, `rt_fwd` out XLEN: combinational forwarded operands for the branch unit.
- `branch` out XLEN: combinational `(imm << 2) + pc_4_in`.
- `offset28` out 28: combinational `{ins[25:0], 2'b00}`.
- `rs_q`, `rt_q`, `imm_q`, `pc_8_q` out XLEN: registered operands, immediate, and PC+8.
- `rs_field_q`, `rt_field_q`, `rd_field_q` out 5: registered `ins[25:21]`, `ins[20:16]`, `ins[15:11]`.
- `bank_q` out bank width: bank captured with the instruction.
- `valid_q` out 1: ID/EX holds a real instruction.

## Operation
- Register 0 of every bank reads 0; writes to it are discarded.
- Read path: `rf[bank_sel][ins[25:21]]` and `rf[bank_sel][ins[20:16]]`.
- Write-through bypass: if `wr_n == 0` and `wr_bank`/`wr_addr` match a read port's bank/address (address ≠ 0), that port returns `wr_data` in the same cycle.
- `rs_fwd`/`rt_fwd` = `ex_mem_data` when `fwd_c`/`fwd_d` is set, else the bypassed read.
  - Forwarding affects the branch outputs only, not `rs_q`/`rt_q`; EX forwards separately.
- Immediate `imm`:
  - `op = ins[31:26]` ∈ {`6'h0C`, `6'h0D`, `6'h0E`} (andi/ori/xori): zero-extend `ins[15:0]` to XLEN.
  - All other opcodes: sign-extend `ins[15:0]`.
- ID/EX register update, priority order:
  1. `flush`: `valid_q` ← 0; all other `*_q` ← 0.
  2. `stall`: hold all fields, with a stale-operand refresh: if `wr_n == 0`, `wr_bank == bank_q` and `wr_addr` matches `rs_field_q` (or `rt_field_q`), non-zero, then `rs_q` (or `rt_q`) ← `wr_data`.
  3. Otherwise capture: `valid_q` ← `valid_in`, `rs_q`/`rt_q` ← bypassed reads, `imm_q` ← `imm`, `pc_8_q` ← `pc_4_in + 4`, fields ← `ins` slices, `bank_q` ← `bank_sel`.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.

## Timing
- Combinational outputs are valid in the same cycle as `ins`.
- Registered outputs have 1-cycle latency.
- A write at edge N is readable through the array from edge N onward; it is visible combinationally in cycle N through the bypass.
- Reset (`reset == 0` at an edge): all banks ← 0 and all `*_q` ← 0, including `valid_q`. Reset beats `flush`, `stall` and writes in the same cycle. Reset mid-stall discards the held instruction.
- Simultaneous `flush` and `stall`: flush wins.
- A write to bank b while `bank_sel ≠ b` updates only bank b; the read is not bypassed.

## Configuration
- `ID_BANK_SWITCH_EN` defined:
  - `NBANK` banks are instantiated.
  - `bank_sel`/`wr_bank` select them.
  - `bank_q` tracks `bank_sel`.
- `ID_BANK_SWITCH_EN` undefined:
  - A single bank is instantiated.
  - `bank_sel` and `wr_bank` are ignored; bank matches are always true.
  - `bank_q` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `ANDI_OP`, `ORI_OP`, `XORI_OP`, `TRAP_OP`;
  - the `XLEN` default;
  - an `id_ex_t` struct for the registered bundle.
- One sub-module: `rf_bank`, an `NREG`×XLEN array with 2 read ports, 1 write port, synchronous active-low reset, and register-0 zeroing. It is instantiated `NBANK` times in a generate loop. Bypass and bank muxing stay in the top level.

## Test plan
- Reset: drive `reset = 0` for 2 cycles → all `*_q` = 0, `valid_q` = 0, all registers read 0.
- Bank isolation: write `32'hDEAD_BEEF` to r5 of bank 1, then read r5 with `bank_sel = 0` → 0. With `bank_sel = 1` → `DEAD_BEEF`. Without the macro, both reads → `DEAD_BEEF`.
- Bypass and forwarding: write r7 = `32'h1234` in the same cycle as `ins` reads rs = r7 → `rs_fwd` = `1234` and `rs_q` = `1234` next cycle. With `fwd_c = 1` and `ex_mem_data = 32'h55` → `rs_fwd` = `55`, while `rs_q` stays `1234`.
- Immediate: `ori` with imm `16'h8000` → `imm_q` = `32'h0000_8000`. `addi` with `16'h8000` → `32'hFFFF_8000`. With `pc_4_in = 32'h100` and imm `16'hFFFF` → `branch` = `32'hFC`.
- Stall refresh: stall with `rt_field_q` = 3, write r3 = `32'h99` in the same bank → `rt_q` = `99` next cycle. All other fields hold.
- Flush priority: `flush = stall = 1` → `valid_q` = 0 and `*_q` = 0. Writing r0 = `32'hFFFF` → r0 still reads 0.
